// File: rtl/tx_port_write_splitter.sv
// Splits a TX channel transaction into PCIe memory-write requests bounded by
// max payload, 4 KB boundaries, the current SG element and uncommitted FIFO data.
module tx_port_write_splitter #(
    parameter int C_FIFO_DEPTH  = 512,
    parameter int C_MAX_PAYLOAD = 2,
    localparam int C_FIFO_DEPTH_WIDTH = $clog2((2**$clog2(C_FIFO_DEPTH)) + 1)
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [2:0]                    CONFIG_MAX_PAYLOAD_SIZE,
    input  logic                          TXN_START,
    input  logic [31:0]                   TXN_LEN,
    output logic                          TXN_DONE,
    output logic [31:0]                   TXN_DONE_LEN,
    input  logic                          SG_ELEM_RDY,
    input  logic [63:0]                   SG_ELEM_ADDR,
    input  logic [31:0]                   SG_ELEM_LEN,
    output logic                          SG_ELEM_REN,
    input  logic [C_FIFO_DEPTH_WIDTH-1:0] FIFO_COUNT,
    input  logic                          FIFO_REN,
    output logic                          TX_REQ,
    input  logic                          TX_REQ_ACK,
    output logic [63:0]                   TX_ADDR,
    output logic [9:0]                    TX_LEN,
    output logic                          TX_LAST
);

    localparam logic [2:0] C_CAP_ENC = (C_MAX_PAYLOAD > 5) ? 3'd5 : 3'(C_MAX_PAYLOAD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ELEM,
        S_CALC,
        S_WAIT,
        S_REQ,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_remain;
    logic [31:0] r_sent;
    logic [63:0] r_addr;
    logic [31:0] r_elem_words;
    logic [31:0] r_len;
    logic [31:0] r_commit;

    logic [2:0]  w_cfg_enc;
    logic [2:0]  w_pay_enc;
    logic [31:0] w_pay_words;
    logic [31:0] w_bound_words;
    logic [31:0] w_calc_len;
    logic [31:0] w_elem_len_words;
    logic [31:0] w_fifo_words;
    logic        w_avail_ok;
    logic [31:0] w_remain_after;
    logic [31:0] w_elem_after;
    logic        w_held;
    logic        w_ack;
    logic        w_unused;

    assign w_elem_len_words = {2'b00, SG_ELEM_LEN[31:2]};
    assign w_fifo_words     = {{(32 - C_FIFO_DEPTH_WIDTH){1'b0}}, FIFO_COUNT};
    assign w_remain_after   = r_remain - r_len;
    assign w_elem_after     = r_elem_words - r_len;
    assign w_held           = (r_elem_words != '0);
    assign w_ack            = (r_state == S_REQ) && TX_REQ_ACK;
    assign w_unused         = &{1'b0, SG_ELEM_LEN[1:0]};

    // Request length: smallest of remainder, element, payload cap and 4 KB boundary.
    always_comb begin
        w_cfg_enc     = (CONFIG_MAX_PAYLOAD_SIZE > 3'd5) ? 3'd5 : CONFIG_MAX_PAYLOAD_SIZE;
        w_pay_enc     = (w_cfg_enc < C_CAP_ENC) ? w_cfg_enc : C_CAP_ENC;
        w_pay_words   = 32'd32 << w_pay_enc;
        w_bound_words = (32'd4096 - {20'd0, r_addr[11:0]}) >> 2;
        w_calc_len    = r_remain;
        if (r_elem_words < w_calc_len) begin
            w_calc_len = r_elem_words;
        end
        if (w_pay_words < w_calc_len) begin
            w_calc_len = w_pay_words;
        end
        if (w_bound_words < w_calc_len) begin
            w_calc_len = w_bound_words;
        end
        w_avail_ok = (w_fifo_words >= r_commit) && ((w_fifo_words - r_commit) >= r_len);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (TXN_START) begin
                    if (TXN_LEN == '0) begin
                        w_next = S_DONE;
                    end else if (w_held) begin
                        w_next = S_CALC;
                    end else begin
                        w_next = S_ELEM;
                    end
                end
            end
            S_ELEM: begin
                if (SG_ELEM_RDY && (w_elem_len_words != '0)) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: w_next = S_WAIT;
            S_WAIT: begin
                if (w_avail_ok) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (TX_REQ_ACK) begin
                    if (w_remain_after == '0) begin
                        w_next = S_DONE;
                    end else if (w_elem_after == '0) begin
                        w_next = S_ELEM;
                    end else begin
                        w_next = S_CALC;
                    end
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_remain     <= '0;
            r_sent       <= '0;
            r_addr       <= '0;
            r_elem_words <= '0;
            r_len        <= '0;
            r_commit     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (TXN_START) begin
                        r_remain <= TXN_LEN;
                        r_sent   <= '0;
                    end
                end
                S_ELEM: begin
                    if (SG_ELEM_RDY) begin
                        r_addr       <= SG_ELEM_ADDR;
                        r_elem_words <= w_elem_len_words;
                    end
                end
                S_CALC: r_len <= w_calc_len;
                S_REQ: begin
                    if (TX_REQ_ACK) begin
                        r_addr       <= r_addr + {30'd0, r_len, 2'b00};
                        r_elem_words <= w_elem_after;
                        r_remain     <= w_remain_after;
                        r_sent       <= r_sent + r_len;
                    end
                end
                default: ;
            endcase
            // Words committed to issued requests but not yet drained by the TX engine.
            if (w_ack) begin
                r_commit <= r_commit + r_len - 32'(FIFO_REN);
            end else if (FIFO_REN && (r_commit != '0)) begin
                r_commit <= r_commit - 32'd1;
            end
        end
    end

    assign TX_REQ       = (r_state == S_REQ);
    assign TX_ADDR      = r_addr;
    assign TX_LEN       = r_len[9:0];
    assign TX_LAST      = (r_state == S_REQ) && (r_len == r_remain);
    assign SG_ELEM_REN  = (r_state == S_ELEM) && SG_ELEM_RDY;
    assign TXN_DONE     = (r_state == S_DONE);
    assign TXN_DONE_LEN = r_sent;

endmodule

// File: tb/tb_tx_port_write_splitter.sv
// Directed bench for tx_port_write_splitter: scoreboard of expected write
// requests, SG element source model and pulse monitors.
module tb_tx_port_write_splitter;

    localparam int W = $clog2((2**$clog2(512)) + 1);

    typedef struct {
        logic [63:0] addr;
        logic [9:0]  len;
        logic        last;
    } req_t;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] len;
    } elem_t;

    logic         CLK;
    logic         RST;
    logic [2:0]   CONFIG_MAX_PAYLOAD_SIZE;
    logic         TXN_START;
    logic [31:0]  TXN_LEN;
    logic         TXN_DONE;
    logic [31:0]  TXN_DONE_LEN;
    logic         SG_ELEM_RDY;
    logic [63:0]  SG_ELEM_ADDR;
    logic [31:0]  SG_ELEM_LEN;
    logic         SG_ELEM_REN;
    logic [W-1:0] FIFO_COUNT;
    logic         FIFO_REN;
    logic         TX_REQ;
    logic         TX_REQ_ACK;
    logic [63:0]  TX_ADDR;
    logic [9:0]   TX_LEN;
    logic         TX_LAST;

    req_t  exp_q[$];
    elem_t elem_q[$];
    int    vectors = 0;
    int    errors = 0;
    int    ren_cnt = 0;
    int    done_cnt = 0;
    int    req_cycles = 0;
    int    ren_base;
    int    done_base;
    int    req_base;

    tx_port_write_splitter #(
        .C_FIFO_DEPTH (512),
        .C_MAX_PAYLOAD(2)
    ) dut (
        .CLK                    (CLK),
        .RST                    (RST),
        .CONFIG_MAX_PAYLOAD_SIZE(CONFIG_MAX_PAYLOAD_SIZE),
        .TXN_START              (TXN_START),
        .TXN_LEN                (TXN_LEN),
        .TXN_DONE               (TXN_DONE),
        .TXN_DONE_LEN           (TXN_DONE_LEN),
        .SG_ELEM_RDY            (SG_ELEM_RDY),
        .SG_ELEM_ADDR           (SG_ELEM_ADDR),
        .SG_ELEM_LEN            (SG_ELEM_LEN),
        .SG_ELEM_REN            (SG_ELEM_REN),
        .FIFO_COUNT             (FIFO_COUNT),
        .FIFO_REN               (FIFO_REN),
        .TX_REQ                 (TX_REQ),
        .TX_REQ_ACK             (TX_REQ_ACK),
        .TX_ADDR                (TX_ADDR),
        .TX_LEN                 (TX_LEN),
        .TX_LAST                (TX_LAST)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // SG element source and pulse counters; presents the queue head, pops on SG_ELEM_REN.
    initial begin
        logic ren_s;
        SG_ELEM_RDY  = 1'b0;
        SG_ELEM_ADDR = '0;
        SG_ELEM_LEN  = '0;
        forever begin
            @(negedge CLK);
            ren_s = SG_ELEM_REN;
            if (SG_ELEM_REN) ren_cnt++;
            if (TXN_DONE) done_cnt++;
            if (TX_REQ) req_cycles++;
            @(posedge CLK);
            #1;
            if (ren_s && (elem_q.size() != 0)) void'(elem_q.pop_front());
            if (elem_q.size() != 0) begin
                SG_ELEM_RDY  = 1'b1;
                SG_ELEM_ADDR = elem_q[0].addr;
                SG_ELEM_LEN  = elem_q[0].len;
            end else begin
                SG_ELEM_RDY = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input logic [63:0] addr, input logic [9:0] len, input logic last);
        req_t r;
        r.addr = addr;
        r.len  = len;
        r.last = last;
        exp_q.push_back(r);
    endtask

    task automatic push_elem(input logic [63:0] addr, input logic [31:0] len);
        elem_t e;
        e.addr = addr;
        e.len  = len;
        elem_q.push_back(e);
    endtask

    task automatic do_reset();
        RST        = 1'b1;
        TXN_START  = 1'b0;
        TX_REQ_ACK = 1'b0;
        FIFO_REN   = 1'b0;
        elem_q.delete();
        exp_q.delete();
        step();
        step();
        RST = 1'b0;
        step();
    endtask

    task automatic start(input logic [31:0] len);
        TXN_START = 1'b1;
        TXN_LEN   = len;
        step();
        TXN_START = 1'b0;
    endtask

    task automatic wait_req();
        int t = 0;
        while ((TX_REQ !== 1'b1) && (t < 200)) begin
            step();
            t++;
        end
        check("req_seen", {63'd0, TX_REQ}, 64'd1);
    endtask

    // Waits for a request, checks it against the scoreboard head, optionally
    // withholds the ack for `hold` cycles while checking stability, then acks.
    task automatic serve_req(input int hold);
        req_t e;
        wait_req();
        if (TX_REQ === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("req_unexpected", {63'd0, TX_REQ}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("req_addr", TX_ADDR, e.addr);
                check("req_len", {54'd0, TX_LEN}, {54'd0, e.len});
                check("req_last", {63'd0, TX_LAST}, {63'd0, e.last});
                for (int i = 0; i < hold; i++) begin
                    step();
                    check("hold_req", {63'd0, TX_REQ}, 64'd1);
                    check("hold_addr", TX_ADDR, e.addr);
                    check("hold_len", {54'd0, TX_LEN}, {54'd0, e.len});
                end
                TX_REQ_ACK = 1'b1;
                step();
                TX_REQ_ACK = 1'b0;
                check("req_drop", {63'd0, TX_REQ}, 64'd0);
            end
        end
    endtask

    task automatic wait_done(input logic [31:0] exp_len);
        int t = 0;
        while ((TXN_DONE !== 1'b1) && (t < 100)) begin
            step();
            t++;
        end
        check("txn_done", {63'd0, TXN_DONE}, 64'd1);
        check("done_len", {32'd0, TXN_DONE_LEN}, {32'd0, exp_len});
        step();
        check("done_pulse", {63'd0, TXN_DONE}, 64'd0);
    endtask

    initial begin
        RST                     = 1'b1;
        CONFIG_MAX_PAYLOAD_SIZE = 3'b010;
        TXN_START               = 1'b0;
        TXN_LEN                 = '0;
        FIFO_COUNT              = 10'd512;
        FIFO_REN                = 1'b0;
        TX_REQ_ACK              = 1'b0;
        repeat (3) step();
        RST = 1'b0;
        step();

        check("rst_req", {63'd0, TX_REQ}, 64'd0);
        check("rst_last", {63'd0, TX_LAST}, 64'd0);
        check("rst_ren", {63'd0, SG_ELEM_REN}, 64'd0);
        check("rst_done", {63'd0, TXN_DONE}, 64'd0);
        check("rst_addr", TX_ADDR, 64'd0);
        check("rst_len", {54'd0, TX_LEN}, 64'd0);
        check("rst_done_len", {32'd0, TXN_DONE_LEN}, 64'd0);

        // Payload-limited split of a single element.
        push_elem(64'h1000, 32'd2000);
        push_req(64'h1000, 10'd128, 1'b0);
        push_req(64'h1200, 10'd128, 1'b0);
        push_req(64'h1400, 10'd44, 1'b1);
        step();
        ren_base = ren_cnt;
        start(32'd300);
        serve_req(0);
        serve_req(0);
        serve_req(0);
        wait_done(32'd300);
        check("t1_ren", 64'(ren_cnt - ren_base), 64'd1);

        // Zero-length transaction with a leftover element held.
        ren_base = ren_cnt;
        req_base = req_cycles;
        start(32'd0);
        check("t5_done", {63'd0, TXN_DONE}, 64'd1);
        check("t5_done_len", {32'd0, TXN_DONE_LEN}, 64'd0);
        step();
        step();
        check("t5_ren", 64'(ren_cnt - ren_base), 64'd0);
        check("t5_req", 64'(req_cycles - req_base), 64'd0);

        // 4 KB boundary split.
        do_reset();
        CONFIG_MAX_PAYLOAD_SIZE = 3'b001;
        push_elem(64'h1FF0, 32'd4096);
        push_req(64'h1FF0, 10'd4, 1'b0);
        push_req(64'h2000, 10'd60, 1'b1);
        step();
        start(32'd64);
        serve_req(0);
        serve_req(0);
        wait_done(32'd64);

        // Element exhaustion with a zero-length element in the list.
        do_reset();
        CONFIG_MAX_PAYLOAD_SIZE = 3'b010;
        push_elem(64'h3000, 32'd40);
        push_elem(64'h4000, 32'd0);
        push_elem(64'h5000, 32'd1000);
        push_req(64'h3000, 10'd10, 1'b0);
        push_req(64'h5000, 10'd90, 1'b1);
        step();
        ren_base = ren_cnt;
        start(32'd100);
        serve_req(0);
        serve_req(0);
        wait_done(32'd100);
        check("t3_ren", 64'(ren_cnt - ren_base), 64'd3);

        // FIFO occupancy gating, then commit accounting across transactions.
        do_reset();
        FIFO_COUNT = 10'd20;
        push_elem(64'h8000, 32'd400);
        push_req(64'h8000, 10'd50, 1'b1);
        step();
        ren_base = ren_cnt;
        req_base = req_cycles;
        start(32'd50);
        repeat (20) step();
        check("t4_stall", 64'(req_cycles - req_base), 64'd0);
        FIFO_COUNT = 10'd50;
        step();
        step();
        check("t4_req_2cyc", {63'd0, TX_REQ}, 64'd1);
        serve_req(0);
        wait_done(32'd50);
        push_req(64'h80C8, 10'd10, 1'b1);
        req_base = req_cycles;
        start(32'd10);
        repeat (10) step();
        check("t4_commit_stall", 64'(req_cycles - req_base), 64'd0);
        FIFO_REN = 1'b1;
        repeat (10) step();
        FIFO_REN = 1'b0;
        serve_req(0);
        wait_done(32'd10);
        check("t4_ren", 64'(ren_cnt - ren_base), 64'd1);

        // Withheld ack, clamped payload encoding, then reset mid-request.
        do_reset();
        FIFO_COUNT              = 10'd512;
        CONFIG_MAX_PAYLOAD_SIZE = 3'b111;
        push_elem(64'h9000, 32'd4096);
        push_req(64'h9000, 10'd128, 1'b0);
        step();
        start(32'd300);
        serve_req(10);
        wait_req();
        check("t6_addr2", TX_ADDR, 64'h9200);
        check("t6_len2", {54'd0, TX_LEN}, 64'd128);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("t6_rst_req", {63'd0, TX_REQ}, 64'd0);
        check("t6_rst_addr", TX_ADDR, 64'd0);
        check("t6_rst_len", {54'd0, TX_LEN}, 64'd0);
        check("t6_rst_last", {63'd0, TX_LAST}, 64'd0);
        check("t6_rst_done_len", {32'd0, TXN_DONE_LEN}, 64'd0);
        exp_q.delete();
        done_base = done_cnt;
        req_base  = req_cycles;
        repeat (20) step();
        check("t6_no_done", 64'(done_cnt - done_base), 64'd0);
        check("t6_no_req", 64'(req_cycles - req_base), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/tx_port_write_splitter.md
Name: tx_port_write_splitter

Overview:
- TX-side counterpart of the RX port's read requester path.
- Takes a channel transaction length in words, pulls scatter-gather elements (host address and byte length), and splits the transfer into PCIe memory-write requests for the TX engine.
- Each request is bounded by: max payload size, 4 KB address boundaries, the current SG element, the transaction remainder, and the uncommitted data already buffered in the TX main FIFO.
- Sits between the TX main FIFO / SG list reader and the TX requester mux; single clock domain (CLK).

Parameters:
- C_FIFO_DEPTH, 512, depth of the TX main FIFO in 32-bit words.
- C_MAX_PAYLOAD, 2, cap on payload encoding (000=128B … 101=4096B); effective = min(CONFIG, C_MAX_PAYLOAD).
- C_FIFO_DEPTH_WIDTH, clog2(2**clog2(C_FIFO_DEPTH)+1), width of FIFO count (local).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- CONFIG_MAX_PAYLOAD_SIZE  in  3  negotiated max payload encoding.
- TXN_START  in  1  one-cycle pulse; latches TXN_LEN; ignored unless idle.
- TXN_LEN  in  32  transaction length in words.
- TXN_DONE  out  1  one-cycle pulse when the transaction is fully requested.
- TXN_DONE_LEN  out  32  words requested in the transaction; held until next TXN_START.
- SG_ELEM_RDY  in  1  SG element available.
- SG_ELEM_ADDR  in  64  element byte address; dword aligned.
- SG_ELEM_LEN  in  32  element byte length; multiple of 4.
- SG_ELEM_REN  out  1  one-cycle pop of the SG element.
- FIFO_COUNT  in  C_FIFO_DEPTH_WIDTH  words present in TX main FIFO.
- FIFO_REN  in  1  one word read from FIFO by TX engine this cycle.
- TX_REQ  out  1  write request valid.
- TX_REQ_ACK  in  1  request accepted.
- TX_ADDR  out  64  request byte address.
- TX_LEN  out  10  request length in words (1..1024; 1024 encoded 0).
- TX_LAST  out  1  request is the final one of the transaction.

Behaviour:
- Reset values: TX_REQ, TX_LAST, SG_ELEM_REN and TXN_DONE = 0; TX_ADDR, TX_LEN and TXN_DONE_LEN = 0; state IDLE; element invalid; commit counter 0.
- State IDLE: on TXN_START latch rRemain=TXN_LEN and clear rSent.
  - TXN_LEN==0 → DONE.
  - Else, if an element is held → CALC; otherwise → ELEM.
- State ELEM: wait for SG_ELEM_RDY, then pulse SG_ELEM_REN for exactly one cycle and load rAddr/rElemWords=SG_ELEM_LEN>>2.
  - Zero-length element: popped and discarded; stay in ELEM.
  - Otherwise → CALC.
- State CALC (one registered cycle): rLen = min(rRemain, rElemWords, 32<<maxpay, (4096-rAddr[11:0])>>2).
  - All terms are 32-bit unsigned.
  - The boundary term is in 1..1024.
  - → WAIT.
- State WAIT: proceed when avail = FIFO_COUNT − rCommit ≥ rLen; then → REQ.
- State REQ: TX_REQ held high with stable TX_ADDR/TX_LEN/TX_LAST until TX_REQ_ACK is sampled high.
  - TX_LAST = (rLen==rRemain).
  - On ack, in the same cycle: TX_REQ←0; rAddr+=rLen*4 (64-bit, carry into upper word); rElemWords−=rLen; rRemain−=rLen; rSent+=rLen; rCommit+=rLen.
  - Next state: rRemain==0 → DONE; else rElemWords==0 → ELEM; else → CALC.
  - TX_REQ_ACK outside REQ is ignored.
- State DONE: TXN_DONE pulses one cycle with TXN_DONE_LEN=rSent → IDLE.
- rCommit accounting: −1 on each FIFO_REN.
  - Simultaneous ack and FIFO_REN: net rCommit += rLen−1.
  - rCommit never underflows; FIFO_REN with rCommit==0 is a protocol violation and saturates at 0.
- Leftover element words at transaction end are retained and used first by the next transaction; only RST discards them.
- Max payload decoding: encoding > 5 is treated as 5.
- TXN_START while not in IDLE is ignored.
- RST mid-request: TX_REQ drops the next cycle; all counters cleared; no TXN_DONE.

Test Plan:
- CONFIG=010, TXN_LEN=300, one element addr 0x1000 len 2000B, FIFO_COUNT=512 → requests (0x1000,128),(0x1200,128),(0x1400,44, LAST); TXN_DONE_LEN=300; one SG_ELEM_REN.
- Element addr 0x1FF0 len 4096B, TXN_LEN=64, CONFIG=001 → (0x1FF0,4),(0x2000,60,LAST): 4 KB split.
- TXN_LEN=100, elements 40B then 0B then 1000B → (A,10),(B,90,LAST); three SG_ELEM_REN pulses (zero element skipped).
- TXN_LEN=50, FIFO_COUNT held at 20 → TX_REQ stays low; raise to 50 → single request of length 50 issued within 2 cycles.
- TXN_LEN=0 → TXN_DONE one cycle after start, TXN_DONE_LEN=0, no SG_ELEM_REN, no TX_REQ.
- TX_REQ_ACK withheld 10 cycles then asserted; RST pulsed during a later TX_REQ → address/length stable while waiting; after reset all outputs 0 and no TXN_DONE.
